// File: rtl/thermal_frame_fetcher.sv
// thermal_frame_fetcher: writes a 16-bit sensor register address, then reads N big-endian 16-bit words through the byte-level I2C controller.
// Define FRAME_FETCH_WATCHDOG_EN to add the busy-edge watchdog that aborts stalled transfers.
module thermal_frame_fetcher #(
    parameter logic [6:0] DEV_ADDR       = 7'h33,
    parameter int         CNT_W          = 10,
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      reg_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             word_valid,
    output logic [15:0]      word_data,
    output logic [CNT_W-1:0] word_index,
    output logic             done,
    output logic             error,
    output logic             ctl_start_transfer,
    output logic [7:0]       ctl_address,
    output logic             ctl_write_mode,
    output logic [7:0]       ctl_transmit_data,
    output logic             ctl_write_pending,
    input  logic             ctl_busy,
    input  logic [7:0]       ctl_received_data
);
    typedef enum logic [2:0] {IDLE, W_REQ, W_SLOT, W_SETTLE, R_REQ, R_SLOT, R_SETTLE, FINISH} state_t;
    localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;

    state_t           state, state_nxt;
    logic             busy_q, slot, rise, settled, abort, rd_slot;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       lo_addr, hi_byte;
    logic [CNT_W:0]   slots;
    logic [CNT_W+1:0] slots_now;
    logic [SW-1:0]    settle_cnt;

    assign ctl_address = {DEV_ADDR, 1'b0};
    assign slot        = busy_q & ~ctl_busy;
    // a rise in the same cycle as our own start request cannot be the controller's answer to it
    assign rise        = ~busy_q & ctl_busy & ~ctl_start_transfer;
    assign settled     = ~ctl_busy && settle_cnt == SW'(SETTLE_CYCLES - 1);
    assign slots_now   = {1'b0, slots} + {{(CNT_W + 1){1'b0}}, slot};
    assign rd_slot     = state == R_SLOT && slot && slots != '0;

`ifdef FRAME_FETCH_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [TW-1:0] wd_cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) wd_cnt <= '0;
        else wd_cnt <= (busy_q != ctl_busy || state == IDLE || state == FINISH) ? '0 : wd_cnt + TW'(1);
    assign abort = state != IDLE && state != FINISH && busy_q == ctl_busy && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) error <= 1'b0;
        else error <= abort;
`else
    assign abort = 1'b0;
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = (word_count == '0) ? FINISH : W_REQ;
            W_REQ:    if (rise) state_nxt = W_SLOT;
            W_SLOT:   if (slot && slots == (CNT_W + 1)'(2)) state_nxt = W_SETTLE;
            W_SETTLE: if (settled) state_nxt = R_REQ;
            R_REQ:    if (rise) state_nxt = R_SLOT;
            R_SLOT:   if (slot && slots == {count_q, 1'b0}) state_nxt = R_SETTLE;
            R_SETTLE: if (settled) state_nxt = FINISH;
            default:  state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // pending must fall within the slot cycle itself, because the controller samples it there
    always_comb begin
        ctl_write_mode    = !(state inside {R_REQ, R_SLOT, R_SETTLE});
        ctl_write_pending = 1'b0;
        case (state)
            W_REQ, R_REQ: ctl_write_pending = 1'b1;
            W_SLOT:       ctl_write_pending = !(slot && slots == (CNT_W + 1)'(2));
            R_SLOT:       ctl_write_pending = slots_now < {1'b0, count_q, 1'b0};
            default:      ctl_write_pending = 1'b0;
        endcase
        if (abort) ctl_write_pending = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q             <= 1'b0;
            ctl_start_transfer <= 1'b0;
            done               <= 1'b0;
            word_valid         <= 1'b0;
            count_q            <= '0;
            lo_addr            <= '0;
            hi_byte            <= '0;
            slots              <= '0;
            settle_cnt         <= '0;
            ctl_transmit_data  <= '0;
            word_data          <= '0;
            word_index         <= '0;
        end else begin
            busy_q             <= ctl_busy;
            ctl_start_transfer <= state_nxt != state && (state_nxt == W_REQ || state_nxt == R_REQ);
            done               <= state == FINISH;
            word_valid         <= rd_slot && !slots[0];
            slots              <= (state == W_REQ || state == R_REQ) ? '0 :
                                  (slot && (state == W_SLOT || state == R_SLOT)) ? slots + (CNT_W + 1)'(1) : slots;
            settle_cnt         <= (state inside {W_SETTLE, R_SETTLE} && !ctl_busy) ? settle_cnt + SW'(1) : '0;
            if (state == IDLE && start) begin
                count_q           <= word_count;
                lo_addr           <= reg_addr[7:0];
                ctl_transmit_data <= reg_addr[15:8];
            end
            if (state == W_SLOT && slot && slots == '0) ctl_transmit_data <= lo_addr;
            // slot k = slots+1 carries byte slots-1: odd slots -> high byte, even -> low byte
            if (rd_slot && slots[0]) hi_byte <= ctl_received_data;
            if (rd_slot && !slots[0]) begin
                word_data  <= {hi_byte, ctl_received_data};
                word_index <= slots[CNT_W:1] - CNT_W'(1);
            end
        end
    end
endmodule
